// File: rtl/gpio_pkg.sv
// gpio_pkg: shared definitions for the modport_gpio pad controller.
//   - default pad count and APB address width
//   - byte offsets of the register map
//   - register-select enum and the address decoder that produces it
package gpio_pkg;

    localparam int unsigned GPIO_W_DEFAULT = 32;
    localparam int unsigned APB_AW_DEFAULT = 6;

    // Register byte offsets
    localparam logic [5:0] RgpioInOfs    = 6'h00;
    localparam logic [5:0] RgpioOutOfs   = 6'h04;
    localparam logic [5:0] RgpioOeOfs    = 6'h08;
    localparam logic [5:0] RgpioInteOfs  = 6'h0C;
    localparam logic [5:0] RgpioPtrigOfs = 6'h10;
    localparam logic [5:0] RgpioEclkOfs  = 6'h14;
    localparam logic [5:0] RgpioNecOfs   = 6'h18;
    localparam logic [5:0] RgpioCtrlOfs  = 6'h1C;
    localparam logic [5:0] RgpioIntsOfs  = 6'h20;

    typedef enum logic [3:0] {
        RegIn,
        RegOut,
        RegOe,
        RegInte,
        RegPtrig,
        RegEclk,
        RegNec,
        RegCtrl,
        RegInts,
        RegNone
    } gpio_reg_e;

    // Word index (byte address bits [5:2]) to register select.
    function automatic gpio_reg_e decode_addr(input logic [3:0] idx);
        gpio_reg_e sel;
        sel = RegNone;
        if (idx == RgpioInOfs[5:2])    sel = RegIn;
        if (idx == RgpioOutOfs[5:2])   sel = RegOut;
        if (idx == RgpioOeOfs[5:2])    sel = RegOe;
        if (idx == RgpioInteOfs[5:2])  sel = RegInte;
        if (idx == RgpioPtrigOfs[5:2]) sel = RegPtrig;
        if (idx == RgpioEclkOfs[5:2])  sel = RegEclk;
        if (idx == RgpioNecOfs[5:2])   sel = RegNec;
        if (idx == RgpioCtrlOfs[5:2])  sel = RegCtrl;
        if (idx == RgpioIntsOfs[5:2])  sel = RegInts;
        return sel;
    endfunction

endpackage

// File: rtl/gpio_sync.sv
// gpio_sync: parameterised-width two-flop synchroniser.
//   clk_i  destination clock
//   rst_i  asynchronous active-high reset (flops clear to 0)
//   d_i    asynchronous input bits
//   q_o    synchronised output, two clk_i edges after d_i settles
module gpio_sync #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/modport_gpio.sv
// modport_gpio: APB slave GPIO pad controller.
//   PCLK, PRESET        clock and asynchronous active-high reset
//   PSEL..PWDATA        APB request; PRDATA/PREADY/PSLVERR response (no wait states)
//   io_pad              bidirectional pads, bit i driven by OUT[i] when OE[i]=1, else high-Z
//   ext_clk_pad_i       external sampling clock, asynchronous to PCLK
//   irq_o               registered interrupt request (CTRL[0] & |INTS)
// Pads and the external clock pass through two-flop synchronisers. Each input bit is
// latched every PCLK, or only on a selected external-clock edge when ECLK[i]=1.
module modport_gpio
    import gpio_pkg::*;
#(
    parameter int unsigned GPIO_W = GPIO_W_DEFAULT,
    parameter int unsigned AW     = APB_AW_DEFAULT
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [AW-1:0]     PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    inout  wire  [GPIO_W-1:0] io_pad,
    input  logic              ext_clk_pad_i,
    output logic              irq_o
);

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [GPIO_W-1:0] in_q, in_d;
    logic [GPIO_W-1:0] in_prev_q;
    logic [GPIO_W-1:0] out_q, out_d;
    logic [GPIO_W-1:0] oe_q, oe_d;
    logic [GPIO_W-1:0] inte_q, inte_d;
    logic [GPIO_W-1:0] ptrig_q, ptrig_d;
    logic [GPIO_W-1:0] eclk_q, eclk_d;
    logic [GPIO_W-1:0] nec_q, nec_d;
    logic              ctrl_q, ctrl_d;
    logic [GPIO_W-1:0] ints_q, ints_d;
    logic              irq_q, irq_d;
    logic              ext_prev_q;

    // ------------------------------------------------------------------
    // APB decode
    // ------------------------------------------------------------------
    gpio_reg_e reg_sel;
    logic      unmapped;
    logic      wr_en;
    logic      unused_paddr;

    assign reg_sel  = decode_addr(PADDR[5:2]);
    assign unmapped = (reg_sel == RegNone);
    assign wr_en    = PSEL & PENABLE & PWRITE & ~unmapped;

    // Byte lanes are not decoded.
    assign unused_paddr = ^PADDR[1:0];

    assign PREADY  = 1'b1;
    assign PSLVERR = PSEL & PENABLE & unmapped;

    always_comb begin
        PRDATA = '0;
        if (PSEL && !PWRITE) begin
            unique case (reg_sel)
                RegIn:    PRDATA = 32'(in_q);
                RegOut:   PRDATA = 32'(out_q);
                RegOe:    PRDATA = 32'(oe_q);
                RegInte:  PRDATA = 32'(inte_q);
                RegPtrig: PRDATA = 32'(ptrig_q);
                RegEclk:  PRDATA = 32'(eclk_q);
                RegNec:   PRDATA = 32'(nec_q);
                RegCtrl:  PRDATA = {31'd0, ctrl_q};
                RegInts:  PRDATA = 32'(ints_q);
                default:  PRDATA = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [GPIO_W-1:0] pad_s;
    logic              ext_s;

    gpio_sync #(
        .Width (GPIO_W)
    ) u_pad_sync (
        .clk_i (PCLK),
        .rst_i (PRESET),
        .d_i   (io_pad),
        .q_o   (pad_s)
    );

    gpio_sync #(
        .Width (1)
    ) u_ext_sync (
        .clk_i (PCLK),
        .rst_i (PRESET),
        .d_i   (ext_clk_pad_i),
        .q_o   (ext_s)
    );

    // ------------------------------------------------------------------
    // Sampling mux and edge/interrupt logic
    // ------------------------------------------------------------------
    logic              ext_rise;
    logic              ext_fall;
    logic [GPIO_W-1:0] ext_hit;
    logic [GPIO_W-1:0] sample_en;
    logic [GPIO_W-1:0] evt;
    logic [GPIO_W-1:0] ints_clr;

    assign ext_rise = ext_s & ~ext_prev_q;
    assign ext_fall = ~ext_s & ext_prev_q;

    // Per-bit: the external edge of the polarity that bit asked for.
    assign ext_hit   = ({GPIO_W{ext_fall}} & nec_q) | ({GPIO_W{ext_rise}} & ~nec_q);
    assign sample_en = ~eclk_q | ext_hit;

    // Events compare the latched value with its previous-cycle copy, so INTS sets one
    // cycle after RGPIO_IN changes.
    assign evt = inte_q & ((in_q & ~in_prev_q & ptrig_q) | (~in_q & in_prev_q & ~ptrig_q));

    always_comb begin
        in_d     = (pad_s & sample_en) | (in_q & ~sample_en);
        out_d    = out_q;
        oe_d     = oe_q;
        inte_d   = inte_q;
        ptrig_d  = ptrig_q;
        eclk_d   = eclk_q;
        nec_d    = nec_q;
        ctrl_d   = ctrl_q;
        ints_clr = '0;

        if (wr_en) begin
            unique case (reg_sel)
                RegOut:   out_d    = PWDATA[GPIO_W-1:0];
                RegOe:    oe_d     = PWDATA[GPIO_W-1:0];
                RegInte:  inte_d   = PWDATA[GPIO_W-1:0];
                RegPtrig: ptrig_d  = PWDATA[GPIO_W-1:0];
                RegEclk:  eclk_d   = PWDATA[GPIO_W-1:0];
                RegNec:   nec_d    = PWDATA[GPIO_W-1:0];
                RegCtrl:  ctrl_d   = PWDATA[0];
                RegInts:  ints_clr = PWDATA[GPIO_W-1:0];
                default:  ;  // RGPIO_IN is read-only; writes are dropped silently
            endcase
        end

        // A new event on a bit beats a simultaneous write-1-to-clear of that bit.
        ints_d = (ints_q & ~ints_clr) | evt;
        irq_d  = ctrl_q & (|ints_q);
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            in_q       <= '0;
            in_prev_q  <= '0;
            out_q      <= '0;
            oe_q       <= '0;
            inte_q     <= '0;
            ptrig_q    <= '0;
            eclk_q     <= '0;
            nec_q      <= '0;
            ctrl_q     <= 1'b0;
            ints_q     <= '0;
            irq_q      <= 1'b0;
            ext_prev_q <= 1'b0;
        end else begin
            in_q       <= in_d;
            in_prev_q  <= in_q;
            out_q      <= out_d;
            oe_q       <= oe_d;
            inte_q     <= inte_d;
            ptrig_q    <= ptrig_d;
            eclk_q     <= eclk_d;
            nec_q      <= nec_d;
            ctrl_q     <= ctrl_d;
            ints_q     <= ints_d;
            irq_q      <= irq_d;
            ext_prev_q <= ext_s;
        end
    end

    assign irq_o = irq_q;

    // ------------------------------------------------------------------
    // Pad drivers
    // ------------------------------------------------------------------
    for (genvar i = 0; i < GPIO_W; i++) begin : g_pad
        assign io_pad[i] = oe_q[i] ? out_q[i] : 1'bz;
    end

endmodule

// File: tb/tb_modport_gpio.sv
// Directed self-checking bench for modport_gpio.
module tb_modport_gpio;

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [5:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    wire  [31:0] io_pad;
    logic        ext_clk;
    logic        irq_o;

    // Bench-side pad drivers
    logic [31:0] pad_drv;
    logic [31:0] pad_en;

    for (genvar i = 0; i < 32; i++) begin : g_tb_pad
        assign io_pad[i] = pad_en[i] ? pad_drv[i] : 1'bz;
    end

    int n_checks;
    int n_errors;

    modport_gpio #(
        .GPIO_W (32),
        .AW     (6)
    ) dut (
        .PCLK          (PCLK),
        .PRESET        (PRESET),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PWRITE        (PWRITE),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PRDATA        (PRDATA),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR),
        .io_pad        (io_pad),
        .ext_clk_pad_i (ext_clk),
        .irq_o         (irq_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input logic [5:0] addr, input logic [31:0] data, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        err = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [5:0] addr, output logic [31:0] data, output logic err);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        data = PRDATA;
        err  = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data);
        logic e;
        apb_write(addr, data, e);
    endtask

    task automatic rd_check(input string tag, input logic [5:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(addr, d, e);
        check_eq(tag, d, exp);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;

        n_checks = 0;
        n_errors = 0;
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; ext_clk = 1'b0;
        pad_en = 32'hFFFF_FFFF; pad_drv = 32'h0;

        // ---------------- Reset ----------------
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check_eq("rst_irq", {31'd0, irq_o}, 32'd0);
        check_eq("rst_slverr", {31'd0, PSLVERR}, 32'd0);
        check_eq("rst_pready", {31'd0, PREADY}, 32'd1);
        PRESET = 1'b0;
        for (int a = 0; a <= 32; a += 4) begin
            apb_read(6'(a), rd, err);
            check_eq($sformatf("rst_rd_%02h", a), rd, 32'h0);
        end
        check_eq("rst_rd_err", {31'd0, err}, 32'd0);
        // Bench drives every pad: readback must match exactly (DUT not driving).
        pad_drv = 32'hCAFE_F00D;
        repeat (4) @(posedge PCLK);
        @(negedge PCLK);
        check_eq("rst_pads_z", io_pad, 32'hCAFE_F00D);
        rd_check("rst_pads_in", 6'h00, 32'hCAFE_F00D);

        // ---------------- Output drive ----------------
        pad_en  = 32'hFFFF_0000;
        pad_drv = 32'h5A5A_0000;
        wr(6'h04, 32'hA5A5_A5A5);
        wr(6'h08, 32'h0000_FFFF);
        check_eq("drv_pads", io_pad, 32'h5A5A_A5A5);
        rd_check("drv_oe", 6'h08, 32'h0000_FFFF);
        rd_check("drv_out", 6'h04, 32'hA5A5_A5A5);
        rd_check("drv_in_readback", 6'h00, 32'h5A5A_A5A5);

        // ---------------- Input latency ----------------
        wr(6'h08, 32'h0);
        pad_en  = 32'hFFFF_FFFF;
        pad_drv = 32'h0;
        repeat (5) @(posedge PCLK);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 6'h00;
        pad_drv = 32'h1234_5678;
        for (int k = 1; k <= 3; k++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            if (k == 2) check_eq("in_lat_edge2", PRDATA, 32'h0);
            if (k == 3) check_eq("in_lat_edge3", PRDATA, 32'h1234_5678);
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0;

        // ---------------- Interrupts ----------------
        pad_drv = 32'h0;
        repeat (5) @(posedge PCLK);
        wr(6'h0C, 32'h1);
        wr(6'h10, 32'h1);
        wr(6'h1C, 32'hFFFF_FFFF);
        rd_check("ctrl_bit0_only", 6'h1C, 32'h1);
        rd_check("ints_idle", 6'h20, 32'h0);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 6'h20;
        pad_drv = 32'h1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            if (k == 3) check_eq("ints_edge3", PRDATA, 32'h0);
            if (k == 4) check_eq("ints_edge4", PRDATA, 32'h1);
            if (k == 4) check_eq("irq_edge4", {31'd0, irq_o}, 32'd0);
            if (k == 5) check_eq("irq_edge5", {31'd0, irq_o}, 32'd1);
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0;
        wr(6'h20, 32'h1);
        @(posedge PCLK);
        @(negedge PCLK);
        check_eq("irq_cleared", {31'd0, irq_o}, 32'd0);
        rd_check("ints_cleared", 6'h20, 32'h0);
        pad_drv = 32'h0;
        repeat (6) @(posedge PCLK);
        rd_check("fall_no_int", 6'h20, 32'h0);
        check_eq("fall_no_irq", {31'd0, irq_o}, 32'd0);
        // Falling-edge trigger with global enable off
        wr(6'h10, 32'h0);
        wr(6'h1C, 32'h0);
        pad_drv = 32'h1;
        repeat (6) @(posedge PCLK);
        rd_check("ptrig0_rise_no_int", 6'h20, 32'h0);
        pad_drv = 32'h0;
        repeat (6) @(posedge PCLK);
        rd_check("ptrig0_fall_int", 6'h20, 32'h1);
        check_eq("ctrl0_masks_irq", {31'd0, irq_o}, 32'd0);
        wr(6'h1C, 32'h1);
        @(posedge PCLK);
        @(negedge PCLK);
        check_eq("ctrl1_irq", {31'd0, irq_o}, 32'd1);
        wr(6'h20, 32'h1);
        wr(6'h0C, 32'h0);

        // ---------------- External clock sampling ----------------
        wr(6'h14, 32'h0000_00FF);
        wr(6'h18, 32'h0);
        pad_drv = 32'hAB00_003C;
        repeat (6) @(posedge PCLK);
        rd_check("eclk_hold", 6'h00, 32'hAB00_0000);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 6'h00;
        ext_clk = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            if (k == 2) check_eq("eclk_rise_edge2", PRDATA, 32'hAB00_0000);
            if (k == 3) check_eq("eclk_rise_edge3", PRDATA, 32'hAB00_003C);
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0;
        wr(6'h18, 32'h0000_00FF);
        pad_drv = 32'hAB00_0081;
        repeat (6) @(posedge PCLK);
        rd_check("nec_no_edge", 6'h00, 32'hAB00_003C);
        ext_clk = 1'b0;
        repeat (5) @(posedge PCLK);
        rd_check("nec_fall_samples", 6'h00, 32'hAB00_0081);
        pad_drv = 32'hAB00_0042;
        repeat (4) @(posedge PCLK);
        ext_clk = 1'b1;
        repeat (5) @(posedge PCLK);
        rd_check("nec_rise_ignored", 6'h00, 32'hAB00_0081);

        // ---------------- Unmapped / read-only ----------------
        apb_write(6'h24, 32'hFFFF_FFFF, err);
        check_eq("unmapped_wr_err", {31'd0, err}, 32'd1);
        apb_read(6'h24, rd, err);
        check_eq("unmapped_rd_data", rd, 32'h0);
        check_eq("unmapped_rd_err", {31'd0, err}, 32'd1);
        apb_read(6'h3C, rd, err);
        check_eq("unmapped_3c_err", {31'd0, err}, 32'd1);
        rd_check("keep_out", 6'h04, 32'hA5A5_A5A5);
        rd_check("keep_oe", 6'h08, 32'h0);
        rd_check("keep_inte", 6'h0C, 32'h0);
        rd_check("keep_ptrig", 6'h10, 32'h0);
        rd_check("keep_eclk", 6'h14, 32'h0000_00FF);
        rd_check("keep_nec", 6'h18, 32'h0000_00FF);
        rd_check("keep_ctrl", 6'h1C, 32'h1);
        rd_check("keep_ints", 6'h20, 32'h0);
        apb_write(6'h00, 32'hFFFF_FFFF, err);
        check_eq("in_wr_no_err", {31'd0, err}, 32'd0);
        rd_check("in_wr_ignored", 6'h00, 32'hAB00_0081);

        // ---------------- Reset mid-transfer ----------------
        wr(6'h14, 32'h0);
        wr(6'h0C, 32'h1);
        wr(6'h10, 32'h1);
        pad_drv = 32'hAB00_0080;
        repeat (5) @(posedge PCLK);
        pad_drv = 32'hAB00_0081;
        repeat (6) @(posedge PCLK);
        @(negedge PCLK);
        check_eq("pre_rst_irq", {31'd0, irq_o}, 32'd1);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 6'h04; PWDATA = 32'h0F0F_0F0F;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        #2;
        PRESET = 1'b1;
        #1;
        check_eq("async_rst_irq", {31'd0, irq_o}, 32'd0);
        @(posedge PCLK);
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PRESET = 1'b0;
        rd_check("abort_out", 6'h04, 32'h0);
        rd_check("abort_ints", 6'h20, 32'h0);
        rd_check("abort_ctrl", 6'h1C, 32'h0);
        rd_check("abort_inte", 6'h0C, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/modport_gpio.md
# modport_gpio

APB-slave GPIO pad controller driving a 32-bit bidirectional pad bus with per-bit tri-state control. Pad inputs are synchronised to PCLK and latched either every PCLK or on a selectable external-clock edge (ext_clk_pad_i). Per-bit edge-triggered interrupts are supported. Sits between the APB fabric and the chip I/O ring.

## Interface
- Parameters:
- GPIO_W, 32, pad count.
- AW, 6, APB address width (byte address; only bits [5:2] decoded).
- Ports:
- PCLK  in  1  system clock, all logic rising-edge.
- PRESET  in  1  reset; asynchronous, active-high.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  AW  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  tied 1 (zero wait states).
- PSLVERR  out  1  error on unmapped address.
- io_pad  inout  GPIO_W  pads; bit i driven with RGPIO_OUT[i] when RGPIO_OE[i]=1, else high-Z.
- ext_clk_pad_i  in  1  external sampling clock (asynchronous to PCLK).
- irq_o  out  1  registered interrupt request.

## Operation
- Registers (offset, access, reset): 0x00 RGPIO_IN RO 0; 0x04 RGPIO_OUT RW 0; 0x08 RGPIO_OE RW 0; 0x0C RGPIO_INTE RW 0; 0x10 RGPIO_PTRIG RW 0 (1=rising, 0=falling); 0x14 RGPIO_ECLK RW 0 (1=bit sampled by ext clock); 0x18 RGPIO_NEC RW 0 (1=ext falling edge, 0=rising); 0x1C RGPIO_CTRL RW 0 (bit0 global INTE, others read 0); 0x20 RGPIO_INTS W1C 0.
- Write commits when PSEL&PENABLE&PWRITE. Read: PRDATA = selected register when PSEL&!PWRITE, else 0.
- Unmapped offset (>0x20) in access phase: PSLVERR=1, write ignored, PRDATA=0. Write to RGPIO_IN ignored, no error.
- Input path: io_pad -> 2-flop synchroniser -> RGPIO_IN. ext_clk_pad_i -> 2-flop synchroniser + previous-value flop for edge detect.
- Bit i with ECLK[i]=0 updates RGPIO_IN[i] every PCLK; ECLK[i]=1 updates only in the cycle a synchronised ext edge of polarity NEC[i] is detected.
- Event on bit i: RGPIO_IN[i] transitions 0->1 with PTRIG[i]=1, or 1->0 with PTRIG[i]=0, and INTE[i]=1. Event sets INTS[i].
- INTS: writing 1 clears bit; event and clear on same bit same cycle -> set wins.
- irq_o = CTRL[0] & |RGPIO_INTS, registered.
- Output-enabled pads still read back through the input path.

## Timing
- Reset: all registers, synchronisers, irq_o = 0; all pads high-Z; PSLVERR 0.
- Register write visible on read the next access; pad drive changes the cycle after the write edge.
- Pad change (ECLK=0) -> RGPIO_IN after 3 PCLK edges; INTS set on edge 4; irq_o on edge 5.
- ext_clk edge -> sampling in PCLK cycle 3 after the edge; ext_clk must be slower than PCLK/3 (faster edges may be lost; not an error).
- PRESET mid-transfer aborts the write; state returns to reset immediately.

## Structure
- Package gpio_pkg: register offset localparams, GPIO_W default, APB address-decode enum.
- One sub-module: gpio_sync (parameterised-width 2-flop synchroniser, async active-high reset), used for io_pad and ext_clk_pad_i.
- Top holds APB decode, register file, sampling mux, edge detect, interrupt logic, tri-state assigns.

## Test plan
- Reset: read all offsets -> 0; pads all Z; irq_o=0.
- Write OUT=0xA5A5A5A5, OE=0x0000FFFF -> io_pad[15:0]=0xA5A5, io_pad[31:16]=Z; read OE -> 0x0000FFFF.
- OE=0, bench drives io_pad=0x12345678 -> RGPIO_IN reads 0x12345678 from the 3rd PCLK edge on.
- INTE=0x1, PTRIG=0x1, CTRL=1; bench raises io_pad[0] -> INTS=0x1, irq_o=1 two cycles after IN updates; write INTS=0x1 -> irq_o=0; falling edge causes no interrupt.
- ECLK=0xFF, NEC=0; change io_pad[7:0] to 0x3C with no ext_clk edge -> IN[7:0] unchanged; one ext_clk rising edge -> IN[7:0]=0x3C.
- Access offset 0x24 -> PSLVERR=1, PRDATA=0, no register modified.
